id_stage: RTL and testbench

Parametrised RV32I decode stage with integrated ID/EX pipeline register, valid/ready handshakes on both sides, N-way operand forwarding and a per-register outstanding-load scoreboard. It sits between the fetch/IF-ID stage and EX. It replaces the single-load "read-after-load stall plus resume" scheme with exact tracking of every load still in flight past EX. All outputs to EX are registered.

---
 rtl/id_stage_pkg.sv | 69 ++++++
 rtl/id_stage_if.sv | 33 +++
 rtl/id_scoreboard.sv | 58 +++++
 rtl/id_stage.sv | 213 +++++++++++++++++++++
 tb/tb_id_stage.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/id_stage_pkg.sv
// Shared decode constants for the RV32I decode stage: opcodes, ALU op/select
// codes, the decoded-instruction record and immediate builders.
package id_stage_pkg;

    localparam int OpcodeLen  = 7;
    localparam int RegAddrLen = 5;
    localparam int Funct3Len  = 3;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    localparam logic [OpcodeLen-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OpcodeLen-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OpcodeLen-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OpcodeLen-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OpcodeLen-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OpcodeLen-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OpcodeLen-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OpcodeLen-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OpcodeLen-1:0] OPC_OP     = 7'b0110011;

    // aluop = {modifier, funct3}; the modifier selects SUB / SRA
    localparam logic [3:0] ALUOP_ADD = 4'b0000;
    localparam logic [3:0] ALUOP_SUB = 4'b1000;
    localparam logic [3:0] ALUOP_SRA = 4'b1101;

    typedef enum logic [2:0] {
        ALUSEL_NOP        = 3'd0,
        ALUSEL_ALU        = 3'd1,
        ALUSEL_LUI        = 3'd2,
        ALUSEL_AUIPC      = 3'd3,
        ALUSEL_JUMP       = 3'd4,
        ALUSEL_BRANCH     = 3'd5,
        ALUSEL_MEM        = 3'd6,
        ALUSEL_MULDIV_RES = 3'd7
    } alusel_e;

    typedef struct packed {
        logic        rs1_re;
        logic        rs2_re;
        logic        rd_we;
        logic        is_load;
        logic        is_store;
        logic        is_jal;
        logic        illegal;
        alusel_e     alusel;
        logic [3:0]  aluop;
        logic [31:0] imm;
    } decode_t;

    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:25], inst[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] inst);
        return {inst[31:12], 12'h000};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// ID -> EX bundle: registered decode payload plus the valid/ready handshake.
interface id_stage_if #(
    parameter int XLEN = 32
);
    logic                   valid;
    logic                   ready;
    logic [XLEN-1:0]        pc;
    logic [XLEN-1:0]        next_pc;
    logic [XLEN-1:0]        jump_pc;
    logic [XLEN-1:0]        rs1_data;
    logic [XLEN-1:0]        rs2_data;
    logic [XLEN-1:0]        imm;
    logic [3:0]             aluop;
    id_stage_pkg::alusel_e  alusel;
    logic [2:0]             funct3;
    logic [4:0]             rd_addr;
    logic                   rd_we;
    logic                   is_load;
    logic                   is_store;
    logic                   illegal;

    modport master (
        output valid, pc, next_pc, jump_pc, rs1_data, rs2_data, imm,
               aluop, alusel, funct3, rd_addr, rd_we, is_load, is_store, illegal,
        input  ready
    );

    modport slave (
        input  valid, pc, next_pc, jump_pc, rs1_data, rs2_data, imm,
               aluop, alusel, funct3, rd_addr, rd_we, is_load, is_store, illegal,
        output ready
    );
endinterface

// File: rtl/id_scoreboard.sv
// Per-register count of loads that left EX but have not written back (x1..x31).
module id_scoreboard
    import id_stage_pkg::*;
#(
    parameter int LD_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  inc_i,
    input  logic [RegAddrLen-1:0] inc_addr_i,
    input  logic                  dec_i,
    input  logic [RegAddrLen-1:0] dec_addr_i,
    input  logic [RegAddrLen-1:0] rs1_addr_i,
    input  logic [RegAddrLen-1:0] rs2_addr_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o,
    input  logic [RegAddrLen-1:0] sat_addr_i,
    input  logic                  sat_extra_i,
    output logic                  sat_o
);
    localparam int CntW = $clog2(LD_OUTSTANDING + 1);

    logic [32*CntW-1:0] cnt_flat;
    logic [CntW-1:0]    sat_cnt;

    genvar gi;
    for (gi = 0; gi < 32; gi++) begin : g_cnt
        if (gi == 0) begin : g_zero
            assign cnt_flat[gi*CntW +: CntW] = '0;
        end else begin : g_reg
            logic [CntW-1:0] cnt_q;
            logic            do_inc;
            logic            do_dec;

            assign do_inc = inc_i && (inc_addr_i == RegAddrLen'(gi));
            // A write-back with nothing outstanding is stale and ignored
            assign do_dec = dec_i && (dec_addr_i == RegAddrLen'(gi)) && (cnt_q != '0);

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else if (do_inc && !do_dec) begin
                    cnt_q <= cnt_q + CntW'(1);
                end else if (do_dec && !do_inc) begin
                    cnt_q <= cnt_q - CntW'(1);
                end
            end

            assign cnt_flat[gi*CntW +: CntW] = cnt_q;
        end
    end

    assign rs1_busy_o = cnt_flat[rs1_addr_i*CntW +: CntW] != '0;
    assign rs2_busy_o = cnt_flat[rs2_addr_i*CntW +: CntW] != '0;
    assign sat_cnt    = cnt_flat[sat_addr_i*CntW +: CntW];
    assign sat_o      = (int'(sat_cnt) + int'(sat_extra_i)) >= LD_OUTSTANDING;

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage with ID/EX register, N-way forwarding and load scoreboard.
// Define ID_RV32M_EN to decode the RV32M OP encodings (funct7 = 0000001).
module id_stage
    import id_stage_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int NUM_FWD        = 2,
    parameter int LD_OUTSTANDING = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          if_valid_i,
    output logic                          if_ready_o,
    input  logic [XLEN-1:0]               if_pc_i,
    input  logic [31:0]                   if_inst_i,
    input  logic                          flush_i,
    output logic [RegAddrLen-1:0]         rf_rs1_addr_o,
    output logic [RegAddrLen-1:0]         rf_rs2_addr_o,
    input  logic [XLEN-1:0]               rf_rs1_data_i,
    input  logic [XLEN-1:0]               rf_rs2_data_i,
    input  logic [NUM_FWD-1:0]            fw_valid_i,
    input  logic [RegAddrLen*NUM_FWD-1:0] fw_addr_i,
    input  logic [XLEN*NUM_FWD-1:0]       fw_data_i,
    input  logic                          ld_done_i,
    input  logic [RegAddrLen-1:0]         ld_done_addr_i,
    id_stage_if.master                    ex,
    output logic                          jump_o,
    output logic [XLEN-1:0]               jump_pc_o
);
    logic [OpcodeLen-1:0]  opcode;
    logic [RegAddrLen-1:0] rs1_addr, rs2_addr, rd_addr;
    logic [Funct3Len-1:0]  funct3;
    logic [6:0]            funct7;
    decode_t               dec;
    logic [XLEN-1:0]       imm_x, rs1_val, rs2_val;
    logic [NUM_FWD-1:0]    fw_hit1, fw_hit2;
    logic sb_busy1, sb_busy2, sb_sat, sat_extra, sb_inc;
    logic hz1, hz2, waw, stall, load_id;

    logic                  ex_valid_q, ex_rd_we_q, ex_is_load_q, ex_is_store_q, ex_illegal_q, jump_q;
    logic [XLEN-1:0]       ex_pc_q, ex_next_pc_q, ex_jump_pc_q, ex_rs1_q, ex_rs2_q, ex_imm_q, jump_pc_q;
    logic [3:0]            ex_aluop_q;
    alusel_e               ex_alusel_q;
    logic [Funct3Len-1:0]  ex_funct3_q;
    logic [RegAddrLen-1:0] ex_rd_addr_q;

    assign opcode   = if_inst_i[6:0];
    assign rd_addr  = if_inst_i[11:7];
    assign funct3   = if_inst_i[14:12];
    assign rs1_addr = if_inst_i[19:15];
    assign rs2_addr = if_inst_i[24:20];
    assign funct7   = if_inst_i[31:25];
    assign rf_rs1_addr_o = rs1_addr;
    assign rf_rs2_addr_o = rs2_addr;

    always_comb begin
        dec        = '0;
        dec.alusel = ALUSEL_NOP;
        case (opcode)
            OPC_LUI:    begin dec.rd_we = 1'b1; dec.imm = imm_u(if_inst_i); dec.alusel = ALUSEL_LUI; end
            OPC_AUIPC:  begin dec.rd_we = 1'b1; dec.imm = imm_u(if_inst_i); dec.alusel = ALUSEL_AUIPC; end
            OPC_JAL:    begin dec.rd_we = 1'b1; dec.imm = imm_j(if_inst_i); dec.alusel = ALUSEL_JUMP; dec.is_jal = 1'b1; end
            OPC_JALR:   begin dec.rs1_re = 1'b1; dec.rd_we = 1'b1; dec.imm = imm_i(if_inst_i); dec.alusel = ALUSEL_JUMP; end
            OPC_BRANCH: begin dec.rs1_re = 1'b1; dec.rs2_re = 1'b1; dec.imm = imm_b(if_inst_i); dec.alusel = ALUSEL_BRANCH; end
            OPC_LOAD:   begin dec.rs1_re = 1'b1; dec.rd_we = 1'b1; dec.imm = imm_i(if_inst_i); dec.alusel = ALUSEL_MEM; dec.is_load = 1'b1; end
            OPC_STORE:  begin dec.rs1_re = 1'b1; dec.rs2_re = 1'b1; dec.imm = imm_s(if_inst_i); dec.alusel = ALUSEL_MEM; dec.is_store = 1'b1; end
            OPC_OPIMM: begin
                dec.rs1_re = 1'b1;
                dec.rd_we  = 1'b1;
                dec.imm    = imm_i(if_inst_i);
                dec.alusel = ALUSEL_ALU;
                dec.aluop  = {(funct3 == 3'b101) && if_inst_i[30], funct3};
            end
            OPC_OP: begin
                if (funct7 == 7'b0000001) begin
`ifdef ID_RV32M_EN
                    dec.rs1_re = 1'b1;
                    dec.rs2_re = 1'b1;
                    dec.rd_we  = 1'b1;
                    dec.alusel = ALUSEL_MULDIV_RES;
                    dec.aluop  = {1'b0, funct3};
`else
                    dec.illegal = 1'b1;
`endif
                end else if (funct7 == 7'b0000000 ||
                             (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    dec.rs1_re = 1'b1;
                    dec.rs2_re = 1'b1;
                    dec.rd_we  = 1'b1;
                    dec.alusel = ALUSEL_ALU;
                    dec.aluop  = {if_inst_i[30], funct3};
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
        if (rd_addr == '0) dec.rd_we = 1'b0;
    end

    assign imm_x = XLEN'($signed(dec.imm));

    genvar gi;
    for (gi = 0; gi < NUM_FWD; gi++) begin : g_fw
        assign fw_hit1[gi] = fw_valid_i[gi] && (fw_addr_i[gi*RegAddrLen +: RegAddrLen] == rs1_addr);
        assign fw_hit2[gi] = fw_valid_i[gi] && (fw_addr_i[gi*RegAddrLen +: RegAddrLen] == rs2_addr);
    end

    // Walk from the oldest source down so the lowest matching index wins
    always_comb begin
        rs1_val = rf_rs1_data_i;
        rs2_val = rf_rs2_data_i;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fw_hit1[k]) rs1_val = fw_data_i[k*XLEN +: XLEN];
            if (fw_hit2[k]) rs2_val = fw_data_i[k*XLEN +: XLEN];
        end
        if (!dec.rs1_re || rs1_addr == '0) rs1_val = '0;
        if (!dec.rs2_re)                   rs2_val = imm_x;
        else if (rs2_addr == '0)           rs2_val = '0;
    end

    assign hz1 = dec.rs1_re && (rs1_addr != '0) &&
                 ((ex_valid_q && ex_is_load_q && ex_rd_addr_q == rs1_addr) || sb_busy1);
    assign hz2 = dec.rs2_re && (rs2_addr != '0) &&
                 ((ex_valid_q && ex_is_load_q && ex_rd_addr_q == rs2_addr) || sb_busy2);
    // The resident load will become one more in-flight load, so count it
    // against the limit to keep the counter from overflowing.
    assign sat_extra = ex_valid_q && ex_is_load_q && (ex_rd_addr_q == rd_addr);
    assign waw       = dec.is_load && (rd_addr != '0) && sb_sat;
    assign stall     = hz1 || hz2 || waw;

    assign if_ready_o = (!stall && (!ex_valid_q || ex.ready)) || flush_i;
    assign load_id    = if_valid_i && if_ready_o && !flush_i;
    assign sb_inc     = ex_valid_q && ex.ready && !flush_i && ex_is_load_q && (ex_rd_addr_q != '0);

    id_scoreboard #(.LD_OUTSTANDING(LD_OUTSTANDING)) u_scoreboard (
        .clk_i       (clk_in),
        .rst_i       (rst_in),
        .inc_i       (sb_inc),
        .inc_addr_i  (ex_rd_addr_q),
        .dec_i       (ld_done_i),
        .dec_addr_i  (ld_done_addr_i),
        .rs1_addr_i  (rs1_addr),
        .rs2_addr_i  (rs2_addr),
        .rs1_busy_o  (sb_busy1),
        .rs2_busy_o  (sb_busy2),
        .sat_addr_i  (rd_addr),
        .sat_extra_i (sat_extra),
        .sat_o       (sb_sat)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_next_pc_q  <= '0;
            ex_jump_pc_q  <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_imm_q      <= '0;
            ex_aluop_q    <= '0;
            ex_alusel_q   <= ALUSEL_NOP;
            ex_funct3_q   <= '0;
            ex_rd_addr_q  <= '0;
            ex_rd_we_q    <= 1'b0;
            ex_is_load_q  <= 1'b0;
            ex_is_store_q <= 1'b0;
            ex_illegal_q  <= 1'b0;
            jump_q        <= 1'b0;
            jump_pc_q     <= '0;
        end else if (load_id) begin
            ex_valid_q    <= 1'b1;
            ex_pc_q       <= if_pc_i;
            ex_next_pc_q  <= if_pc_i + XLEN'(4);
            ex_jump_pc_q  <= if_pc_i + imm_x;
            ex_rs1_q      <= rs1_val;
            ex_rs2_q      <= rs2_val;
            ex_imm_q      <= imm_x;
            ex_aluop_q    <= dec.aluop;
            ex_alusel_q   <= dec.alusel;
            ex_funct3_q   <= funct3;
            ex_rd_addr_q  <= rd_addr;
            ex_rd_we_q    <= dec.rd_we;
            ex_is_load_q  <= dec.is_load;
            ex_is_store_q <= dec.is_store;
            ex_illegal_q  <= dec.illegal;
            jump_q        <= dec.is_jal;
            if (dec.is_jal) jump_pc_q <= if_pc_i + imm_x;
        end else begin
            jump_q <= 1'b0;
            if (ex.ready || flush_i) ex_valid_q <= 1'b0;
        end
    end

    assign ex.valid    = ex_valid_q;
    assign ex.pc       = ex_pc_q;
    assign ex.next_pc  = ex_next_pc_q;
    assign ex.jump_pc  = ex_jump_pc_q;
    assign ex.rs1_data = ex_rs1_q;
    assign ex.rs2_data = ex_rs2_q;
    assign ex.imm      = ex_imm_q;
    assign ex.aluop    = ex_aluop_q;
    assign ex.alusel   = ex_alusel_q;
    assign ex.funct3   = ex_funct3_q;
    assign ex.rd_addr  = ex_rd_addr_q;
    assign ex.rd_we    = ex_rd_we_q;
    assign ex.is_load  = ex_is_load_q;
    assign ex.is_store = ex_is_store_q;
    assign ex.illegal  = ex_illegal_q;
    assign jump_o      = jump_q;
    assign jump_pc_o   = jump_pc_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: two instances (LD_OUTSTANDING 2 and 1) share stimulus.
module tb_id_stage;
    import id_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        flush;
    logic [31:0] rf1_data, rf2_data;
    logic [1:0]  fw_valid;
    logic [9:0]  fw_addr;
    logic [63:0] fw_data;
    logic        ld_done;
    logic [4:0]  ld_done_addr;
    logic        ex_ready;

    logic        rdy0, rdy1, jmp0, jmp1;
    logic [31:0] jpc0, jpc1;
    logic [4:0]  ra1_0, ra2_0, ra1_1, ra2_1;

    int checks   = 0;
    int failures = 0;

    id_stage_if #(.XLEN(32)) if0 ();
    id_stage_if #(.XLEN(32)) if1 ();
    assign if0.ready = ex_ready;
    assign if1.ready = ex_ready;

    id_stage #(.XLEN(32), .NUM_FWD(2), .LD_OUTSTANDING(2)) dut (
        .clk_in(clk), .rst_in(rst), .if_valid_i(if_valid), .if_ready_o(rdy0),
        .if_pc_i(if_pc), .if_inst_i(if_inst), .flush_i(flush),
        .rf_rs1_addr_o(ra1_0), .rf_rs2_addr_o(ra2_0),
        .rf_rs1_data_i(rf1_data), .rf_rs2_data_i(rf2_data),
        .fw_valid_i(fw_valid), .fw_addr_i(fw_addr), .fw_data_i(fw_data),
        .ld_done_i(ld_done), .ld_done_addr_i(ld_done_addr),
        .ex(if0.master), .jump_o(jmp0), .jump_pc_o(jpc0)
    );

    id_stage #(.XLEN(32), .NUM_FWD(2), .LD_OUTSTANDING(1)) dut1 (
        .clk_in(clk), .rst_in(rst), .if_valid_i(if_valid), .if_ready_o(rdy1),
        .if_pc_i(if_pc), .if_inst_i(if_inst), .flush_i(flush),
        .rf_rs1_addr_o(ra1_1), .rf_rs2_addr_o(ra2_1),
        .rf_rs1_data_i(rf1_data), .rf_rs2_data_i(rf2_data),
        .fw_valid_i(fw_valid), .fw_addr_i(fw_addr), .fw_data_i(fw_data),
        .ld_done_i(ld_done), .ld_done_addr_i(ld_done_addr),
        .ex(if1.master), .jump_o(jmp1), .jump_pc_o(jpc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] inst);
        if_valid = 1'b1;
        if_pc    = pc;
        if_inst  = inst;
    endtask

    task automatic idle();
        if_valid = 1'b0;
        if_inst  = 32'h0000_0013;
    endtask

    task automatic reset_all();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        if_pc = '0; flush = 0; rf1_data = 32'hDEAD_0001; rf2_data = 32'hDEAD_0002;
        fw_valid = '0; fw_addr = '0; fw_data = '0; ld_done = 0; ld_done_addr = '0; ex_ready = 1;

        reset_all();
        check_val("rst_ex_valid", if0.valid, 0);
        check_val("rst_jump", jmp0, 0);
        check_val("rst_jump_pc", jpc0, 0);
        check_val("rst_ex_pc", if0.pc, 0);
        check_val("rst_rs2_data", if0.rs2_data, 0);
        check_val("rst_if_ready", rdy0, 1);

        // ADDI x1,x0,5
        present(32'h100, 32'h0050_0093);
        tick(); idle(); #1;
        check_val("addi_valid", if0.valid, 1);
        check_val("addi_rs2", if0.rs2_data, 5);
        check_val("addi_rs1", if0.rs1_data, 0);
        check_val("addi_rd", if0.rd_addr, 1);
        check_val("addi_we", if0.rd_we, 1);
        check_val("addi_next_pc", if0.next_pc, 32'h104);
        check_val("addi_alusel", if0.alusel, ALUSEL_ALU);
        tick();
        check_val("addi_drained", if0.valid, 0);

        // LW x2,0(x1) then ADD x3,x2,x2
        present(32'h104, 32'h0000_A103);
        tick();
        present(32'h108, 32'h0021_01B3); #1;
        check_val("lw_resident_isload", if0.is_load, 1);
        check_val("raw_resident_ready", rdy0, 0);
        tick();
        check_val("lw_transferred", if0.valid, 0);
        check_val("raw_cnt_ready_c1", rdy0, 0);
        tick();
        check_val("raw_cnt_ready_c2", rdy0, 0);
        tick();
        check_val("raw_cnt_ready_c3", rdy0, 0);
        ld_done = 1; ld_done_addr = 5'd2;
        tick();
        ld_done = 0;
        fw_valid = 2'b01; fw_addr = {5'd0, 5'd2}; fw_data = {32'h0, 32'h0000_1234}; #1;
        check_val("raw_released_ready", rdy0, 1);
        tick();
        idle(); fw_valid = '0; #1;
        check_val("add_valid", if0.valid, 1);
        check_val("add_rs1_fw", if0.rs1_data, 32'h1234);
        check_val("add_rs2_fw", if0.rs2_data, 32'h1234);
        check_val("add_rd", if0.rd_addr, 3);

        // ADD x6,x5,x0 with forwarding priority
        present(32'h10C, 32'h0002_8333);
        fw_valid = 2'b11; fw_addr = {5'd5, 5'd5}; fw_data = {32'h0000_BBBB, 32'h0000_AAAA};
        tick();
        fw_valid = 2'b10; #1;
        check_val("fw_prio_rs1", if0.rs1_data, 32'hAAAA);
        check_val("fw_x0_rs2", if0.rs2_data, 0);
        tick();
        fw_valid = 2'b00; #1;
        check_val("fw1_only_rs1", if0.rs1_data, 32'hBBBB);
        tick();
        idle(); #1;
        check_val("fw_none_rf_rs1", if0.rs1_data, 32'hDEAD_0001);
        tick();

        // JAL x1,+8
        present(32'h200, 32'h0080_00EF);
        tick(); idle(); #1;
        check_val("jal_jump", jmp0, 1);
        check_val("jal_jump_pc", jpc0, 32'h208);
        check_val("jal_next_pc", if0.next_pc, 32'h204);
        check_val("jal_ex_jump_pc", if0.jump_pc, 32'h208);
        tick();
        check_val("jal_pulse_end", jmp0, 0);
        present(32'h300, 32'h0080_00EF); flush = 1; #1;
        check_val("flush_ready", rdy0, 1);
        tick();
        flush = 0; idle(); #1;
        check_val("jal_flush_jump", jmp0, 0);
        check_val("jal_flush_valid", if0.valid, 0);
        check_val("jal_flush_jpc_held", jpc0, 32'h208);

        // SUB, ADDI x0, unknown opcode, MUL
        present(32'h400, 32'h4031_00B3); #1;
        check_val("sub_rf_addr1", ra1_0, 2);
        check_val("sub_rf_addr2", ra2_0, 3);
        tick();
        present(32'h404, 32'h0010_0013); #1;
        check_val("sub_aluop", if0.aluop, ALUOP_SUB);
        check_val("sub_rs2_rf", if0.rs2_data, 32'hDEAD_0002);
        tick();
        present(32'h408, 32'hFFFF_FFFF); #1;
        check_val("addi_x0_we", if0.rd_we, 0);
        tick();
        present(32'h40C, 32'h0220_81B3); #1;
        check_val("unk_illegal", if0.illegal, 1);
        check_val("unk_we", if0.rd_we, 0);
        tick();
        idle(); #1;
`ifdef ID_RV32M_EN
        check_val("mul_alusel", if0.alusel, ALUSEL_MULDIV_RES);
        check_val("mul_we", if0.rd_we, 1);
        check_val("mul_illegal", if0.illegal, 0);
`else
        check_val("mul_illegal", if0.illegal, 1);
        check_val("mul_we", if0.rd_we, 0);
        check_val("mul_alusel", if0.alusel, ALUSEL_NOP);
`endif
        tick();

        // Two LW x4 against LD_OUTSTANDING 1 (dut1) and 2 (dut)
        reset_all();
        present(32'h500, 32'h0000_2203);
        tick();
        present(32'h504, 32'h0000_2203); #1;
        check_val("waw1_resident_ready", rdy1, 0);
        check_val("waw2_resident_ready", rdy0, 1);
        tick();
        check_val("waw1_lw1_gone", if1.valid, 0);
        check_val("waw1_cnt_ready", rdy1, 0);
        tick();
        check_val("waw1_cnt_ready2", rdy1, 0);
        ld_done = 1; ld_done_addr = 5'd4;
        tick();
        ld_done = 0; #1;
        check_val("waw1_released", rdy1, 1);
        tick();
        idle(); #1;
        check_val("waw1_lw2_valid", if1.valid, 1);
        check_val("waw1_lw2_rd", if1.rd_addr, 4);
        check_val("waw1_lw2_pc", if1.pc, 32'h504);

        // Flush of resident LW x7, then a reader of x7
        reset_all();
        ex_ready = 0;
        present(32'h600, 32'h0000_2383);
        tick();
        idle(); flush = 1; #1;
        check_val("flush_lw_resident", if1.valid, 1);
        tick();
        flush = 0; ex_ready = 1;
        present(32'h604, 32'h0003_8433); #1;
        check_val("flush_lw_killed", if1.valid, 0);
        check_val("flush_reader_ready", rdy1, 1);
        tick();
        idle(); #1;
        check_val("flush_reader_valid", if1.valid, 1);
        check_val("flush_reader_rd", if1.rd_addr, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
